// File: rtl/xadc_drp_sampler.sv
// xadc_drp_sampler: reads the switch-selected XADC channel over DRP on each
// end-of-conversion and averages 2^AVG_LOG2 results into a 12-bit sample.
module xadc_drp_sampler #(
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 63
) (
    input  logic        CLK100MHZ,
    input  logic        ck_rst,
    input  logic [3:0]  sw,
    input  logic        eoc_in,
    input  logic        drdy_in,
    input  logic [15:0] do_in,
    output logic [6:0]  daddr_out,
    output logic        den_out,
    output logic        dwe_out,
    output logic [11:0] sample_out,
    output logic        sample_valid,
    output logic [3:0]  channel_out,
    output logic        timeout_err
);
    localparam int AW = 12 + AVG_LOG2;
    localparam int NW = AVG_LOG2 + 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [NW-1:0] N_SAMP = NW'(1 << AVG_LOG2);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, ACC} state_t;

    state_t          state;
    logic [3:0]      sw_meta, sw_sync;
    logic [3:0]      code, ch, win_ch;
    logic [6:0]      addr;
    logic [11:0]     data;
    logic [AW-1:0]   acc, sum;
    logic [NW-1:0]   n, nxt_n;
    logic [CW-1:0]   cnt;
    logic            restart;
    logic            unused;

    assign dwe_out = 1'b0;
    assign unused  = ^do_in[3:0];

    always_comb begin
        code = sw_sync > 4'd8 ? 4'd0 : sw_sync;
        addr = 7'h14;
        case (code)
            4'd1:    addr = 7'h15;
            4'd2:    addr = 7'h16;
            4'd3:    addr = 7'h17;
            4'd4:    addr = 7'h1F;
            4'd5:    addr = 7'h10;
            4'd6:    addr = 7'h1C;
            4'd7:    addr = 7'h1D;
            4'd8:    addr = 7'h1E;
            default: addr = 7'h14;
        endcase
    end

    // A window restarts when empty or when the read belongs to a different channel
    always_comb begin
        restart = (n == '0) || (ch != win_ch);
        sum     = (restart ? '0 : acc) + AW'(data);
        nxt_n   = (restart ? '0 : n) + NW'(1);
    end

    always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
        if (!ck_rst) begin
            state        <= IDLE;
            sw_meta      <= '0;
            sw_sync      <= '0;
            daddr_out    <= 7'h14;
            den_out      <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            channel_out  <= '0;
            timeout_err  <= 1'b0;
            ch           <= '0;
            win_ch       <= '0;
            data         <= '0;
            acc          <= '0;
            n            <= '0;
            cnt          <= '0;
        end else begin
            sw_meta      <= sw;
            sw_sync      <= sw_meta;
            den_out      <= 1'b0;
            sample_valid <= 1'b0;
            timeout_err  <= 1'b0;
            case (state)
                IDLE: if (eoc_in) begin
                    daddr_out <= addr;
                    ch        <= code;
                    den_out   <= 1'b1;
                    state     <= REQ;
                end
                REQ: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                // Give-up point chosen so the error pulse lands TIMEOUT cycles after den
                WAIT: if (drdy_in) begin
                    data  <= do_in[15:4];
                    state <= ACC;
                end else if (cnt == CW'(TIMEOUT - 2)) begin
                    timeout_err <= 1'b1;
                    state       <= IDLE;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                ACC: begin
                    state  <= IDLE;
                    win_ch <= ch;
                    if (nxt_n == N_SAMP) begin
                        sample_out   <= sum[AVG_LOG2 +: 12];
                        channel_out  <= ch;
                        sample_valid <= 1'b1;
                        acc          <= '0;
                        n            <= '0;
                    end else begin
                        acc <= sum;
                        n   <= nxt_n;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xadc_drp_sampler.sv
// tb_xadc_drp_sampler: randomized DRP reads checked against a window-average model.
module tb_xadc_drp_sampler;
    logic        clk = 1'b0;
    logic        ck_rst;
    logic [3:0]  sw;
    logic        eoc_in, drdy_in;
    logic [15:0] do_in;
    logic [6:0]  daddr_out;
    logic        den_out, dwe_out, sample_valid, timeout_err;
    logic [11:0] sample_out;
    logic [3:0]  channel_out;

    int checks = 0;
    int failures = 0;

    logic [6:0] amap [9] = '{7'h14, 7'h15, 7'h16, 7'h17, 7'h1F, 7'h10, 7'h1C, 7'h1D, 7'h1E};
    int          q[$];
    int          win_code = -1;
    logic [11:0] exp_sample = '0;
    logic [3:0]  exp_ch = '0;
    logic [3:0]  cur_sw = '0;

    xadc_drp_sampler #(.AVG_LOG2(2), .TIMEOUT(63)) dut (
        .CLK100MHZ(clk), .ck_rst(ck_rst), .sw(sw), .eoc_in(eoc_in),
        .drdy_in(drdy_in), .do_in(do_in), .daddr_out(daddr_out),
        .den_out(den_out), .dwe_out(dwe_out), .sample_out(sample_out),
        .sample_valid(sample_valid), .channel_out(channel_out),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        win_code   = -1;
        exp_sample = '0;
        exp_ch     = '0;
    endtask

    task automatic select(input logic [3:0] s);
        sw = s;
        cur_sw = s;
        repeat (3) tick();
    endtask

    task automatic start_read(output int code);
        code = cur_sw > 8 ? 0 : int'(cur_sw);
        eoc_in = 1'b1;
        tick();
        eoc_in = 1'b0;
        check("den_pulse", den_out, 1);
        check("daddr", daddr_out, amap[code]);
        check("dwe", dwe_out, 0);
    endtask

    task automatic do_read(input logic [15:0] d, input int dly, input bit noisy);
        int  code, sum;
        bit  done;
        start_read(code);
        tick();
        check("den_one_cycle", den_out, 0);
        for (int i = 0; i < dly; i++) begin
            eoc_in = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            drdy_in = 1'b0;
            tick();
            check("den_in_wait", den_out, 0);
        end
        eoc_in  = 1'b0;
        drdy_in = 1'b1;
        do_in   = d;
        tick();
        drdy_in = 1'b0;
        do_in   = 16'($urandom);
        if (q.size() != 0 && code != win_code) q.delete();
        win_code = code;
        q.push_back(int'(d >> 4));
        done = q.size() == 4;
        if (done) begin
            sum = 0;
            foreach (q[i]) sum += q[i];
            exp_sample = 12'(sum / 4);
            exp_ch     = 4'(code);
            q.delete();
        end
        check("valid_early", sample_valid, 0);
        tick();
        check("valid", sample_valid, done);
        check("sample", sample_out, exp_sample);
        check("channel", channel_out, exp_ch);
        tick();
        check("valid_one_cycle", sample_valid, 0);
    endtask

    task automatic do_timeout();
        int code;
        start_read(code);
        for (int k = 1; k <= 64; k++) begin
            tick();
            check("timeout_err", timeout_err, k == 63);
            check("no_valid_on_timeout", sample_valid, 0);
        end
    endtask

    initial begin
        int code;
        ck_rst = 1'b0; sw = '0; eoc_in = 1'b0; drdy_in = 1'b0; do_in = '0;
        model_reset();
        repeat (3) tick();
        check("rst_daddr", daddr_out, 7'h14);
        check("rst_den", den_out, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_sample", sample_out, 0);
        check("rst_channel", channel_out, 0);
        check("rst_timeout", timeout_err, 0);
        ck_rst = 1'b1;
        repeat (2) tick();

        select(4'd0);
        do_read(16'h0010, 3, 0);
        do_read(16'h0020, 1, 0);
        do_read(16'h0030, 5, 1);
        do_read(16'h0041, 0, 0);
        check("avg_directed", sample_out, 12'h002);

        select(4'd2);
        do_read(16'h1230, 2, 0);
        do_read(16'h4560, 2, 0);
        select(4'd7);
        for (int i = 0; i < 4; i++) do_read(16'(16'h0100 * (i + 1)), 2, 1);
        check("chan7", channel_out, 7);

        select(4'd12);
        do_read(16'hFFF0, 1, 0);
        check("sw12_daddr", daddr_out, 7'h14);

        do_timeout();
        select(4'd1);
        do_read(16'hABC0, 3, 0);

        select(4'd5);
        start_read(code);
        repeat (4) tick();
        ck_rst = 1'b0;
        #1;
        check("arst_den", den_out, 0);
        check("arst_daddr", daddr_out, 7'h14);
        check("arst_sample", sample_out, 0);
        check("arst_channel", channel_out, 0);
        check("arst_valid", sample_valid, 0);
        check("arst_timeout", timeout_err, 0);
        model_reset();
        tick();
        ck_rst = 1'b1;
        drdy_in = 1'b1;
        do_in = 16'h5550;
        tick();
        drdy_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("late_drdy_valid", sample_valid, 0);
            check("late_drdy_den", den_out, 0);
        end

        for (int r = 0; r < 60; r++) begin
            if (r == 0 || $urandom_range(0, 9) < 3) select(4'($urandom_range(0, 15)));
            do_read(16'($urandom), $urandom_range(0, 20), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
